// File: rtl/rr_bus_mux_arb.sv
// Round-robin arbiter + word-select mux into a registered output stage; grant held for up to MAX_BURST words.
// Latency: request to grant 1 clk, grant to dout_valid 1 clk; req_ready follows out_free so dout backpressure stalls the granted requester.
module rr_bus_mux_arb #(
    parameter int DAT_WIDTH = 16,
    parameter int SEL_WIDTH = 3,
    parameter int NUM_REQ   = 1 << SEL_WIDTH,
    parameter int MAX_BURST = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [DAT_WIDTH*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [DAT_WIDTH-1:0]         dout,
    output logic                         dout_valid,
    input  logic                         dout_ready,
    output logic [SEL_WIDTH-1:0]         dout_src
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {S_IDLE = 1'b0, S_GRANT = 1'b1} state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SEL_WIDTH-1:0]   r_ptr;
    logic [SEL_WIDTH-1:0]   r_sel;
    logic [CNT_W-1:0]       r_burst_cnt;
    logic [DAT_WIDTH-1:0]   r_dout;
    logic                   r_dout_vld;
    logic [SEL_WIDTH-1:0]   r_dout_src;

    logic                   w_out_free;
    logic                   w_any;
    logic [SEL_WIDTH-1:0]   w_pick;
    logic                   w_xfer;
    logic                   w_last;
    logic                   w_abandon;
    logic                   w_exit;
    logic [DAT_WIDTH-1:0]   w_word;

    assign w_out_free = !r_dout_vld || dout_ready;
    assign w_any      = |req_valid;
    assign w_word     = req_data[r_sel*DAT_WIDTH +: DAT_WIDTH];
    assign w_xfer     = (r_state == S_GRANT) && req_valid[r_sel] && w_out_free;
    assign w_last     = w_xfer && (r_burst_cnt == CNT_W'(MAX_BURST - 1));
    assign w_abandon  = (r_state == S_GRANT) && !req_valid[r_sel];
    assign w_exit     = w_last || w_abandon;

    // Scan downwards so the requester closest to r_ptr is the one left standing.
    always_comb begin
        w_pick = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[r_ptr + SEL_WIDTH'(k)]) begin
                w_pick = r_ptr + SEL_WIDTH'(k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_any)  w_state_nxt = S_GRANT;
            S_GRANT: if (w_exit) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (r_state == S_GRANT) begin
            req_ready[r_sel] = w_out_free;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= '0;
            r_sel       <= '0;
            r_burst_cnt <= '0;
            r_dout      <= '0;
            r_dout_vld  <= 1'b0;
            r_dout_src  <= '0;
        end else begin
            if (r_state == S_IDLE) begin
                if (w_any) begin
                    r_sel       <= w_pick;
                    r_burst_cnt <= '0;
                end
            end else if (w_exit) begin
                // Just-served requester drops to lowest priority.
                r_ptr <= r_sel + SEL_WIDTH'(1);
            end
            if (w_xfer) begin
                r_burst_cnt <= r_burst_cnt + CNT_W'(1);
                r_dout      <= w_word;
                r_dout_src  <= r_sel;
                r_dout_vld  <= 1'b1;
            end else if (dout_ready) begin
                r_dout_vld  <= 1'b0;
            end
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_vld;
    assign dout_src   = r_dout_src;

endmodule

// File: tb/tb_rr_bus_mux_arb.sv
// Bench for rr_bus_mux_arb: directed scenarios plus randomized traffic against a transaction-level model.
module tb_rr_bus_mux_arb;

    localparam int DW = 16;
    localparam int SW = 3;
    localparam int NR = 8;
    localparam int MB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic [NR-1:0]       req_valid;
    logic [DW*NR-1:0]    req_data;
    logic [NR-1:0]       req_ready;
    logic [DW-1:0]       dout;
    logic                dout_valid;
    logic                dout_ready;
    logic [SW-1:0]       dout_src;

    logic [NR-1:0]       d1_req_valid;
    logic [DW*NR-1:0]    d1_req_data;
    logic [NR-1:0]       d1_req_ready;
    logic [DW-1:0]       d1_dout;
    logic                d1_dout_valid;
    logic                d1_dout_ready;
    logic [SW-1:0]       d1_dout_src;

    int n_checks = 0;
    int n_fail   = 0;

    rr_bus_mux_arb #(.DAT_WIDTH(DW), .SEL_WIDTH(SW), .MAX_BURST(MB)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .dout(dout), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .dout_src(dout_src)
    );

    rr_bus_mux_arb #(.DAT_WIDTH(DW), .SEL_WIDTH(SW), .MAX_BURST(1)) u_dut1 (
        .clk(clk), .rst(rst), .req_valid(d1_req_valid), .req_data(d1_req_data),
        .req_ready(d1_req_ready), .dout(d1_dout), .dout_valid(d1_dout_valid),
        .dout_ready(d1_dout_ready), .dout_src(d1_dout_src)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        req_valid     = '0;
        req_data      = '0;
        dout_ready    = 1'b1;
        d1_req_valid  = '0;
        d1_req_data   = '0;
        d1_dout_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    function automatic int first_from(int start, logic [NR-1:0] v);
        for (int k = 0; k < NR; k++) begin
            if (v[(start + k) % NR]) return (start + k) % NR;
        end
        return -1;
    endfunction

    task automatic test_reset();
        do_reset();
        rst       = 1'b1;
        req_valid = '1;
        req_data  = {NR{16'hFFFF}};
        tick();
        tick();
        n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dout_valid got=%b exp=0", dout_valid); end
        n_checks++; if (dout !== 16'h0) begin n_fail++; $display("FAIL reset_dout got=%h exp=0000", dout); end
        n_checks++; if (dout_src !== 3'd0) begin n_fail++; $display("FAIL reset_dout_src got=%0d exp=0", dout_src); end
        n_checks++; if (req_ready !== 8'h00) begin n_fail++; $display("FAIL reset_req_ready got=%b exp=00000000", req_ready); end
        n_checks++; if (d1_dout_valid !== 1'b0) begin n_fail++; $display("FAIL reset_d1_dout_valid got=%b exp=0", d1_dout_valid); end
        rst       = 1'b0;
        req_valid = '0;
    endtask

    task automatic test_single_burst();
        int  seq;
        bit  acc;
        bit  exp_vld;
        int  widx;
        do_reset();
        seq       = 0;
        req_valid = 8'b0000_0100;
        for (int e = 1; e <= 12; e++) begin
            req_data[2*DW +: DW] = 16'h0A00 + 16'(seq);
            #1;
            acc = req_ready[2];
            tick();
            if (acc) seq++;
            exp_vld = (e >= 2) && (((e - 2) % 5) < 4);
            widx    = ((e - 2) / 5) * 4 + ((e - 2) % 5);
            n_checks++;
            if (dout_valid !== exp_vld) begin
                n_fail++; $display("FAIL single_burst_vld edge=%0d got=%b exp=%b", e, dout_valid, exp_vld);
            end else if (exp_vld) begin
                n_checks++;
                if (dout !== 16'h0A00 + 16'(widx) || dout_src !== 3'd2) begin
                    n_fail++; $display("FAIL single_burst_word edge=%0d got=%h/%0d exp=%h/2", e, dout, dout_src, 16'h0A00 + 16'(widx));
                end
            end
        end
    endtask

    task automatic test_round_robin_burst1();
        int exp_src;
        do_reset();
        d1_req_valid = '1;
        for (int i = 0; i < NR; i++) d1_req_data[i*DW +: DW] = 16'hB000 + 16'(i);
        for (int e = 1; e <= 18; e++) begin
            tick();
            n_checks++;
            if ((e % 2) == 1) begin
                if (d1_dout_valid !== 1'b0) begin n_fail++; $display("FAIL rr_gap edge=%0d got=%b exp=0", e, d1_dout_valid); end
            end else begin
                exp_src = (e / 2 - 1) % NR;
                if (d1_dout_valid !== 1'b1 || d1_dout_src !== 3'(exp_src) || d1_dout !== 16'hB000 + 16'(exp_src)) begin
                    n_fail++; $display("FAIL rr_word edge=%0d got=%b/%0d/%h exp=1/%0d/%h", e, d1_dout_valid, d1_dout_src, d1_dout, exp_src, 16'hB000 + 16'(exp_src));
                end
            end
        end
        d1_req_valid = '0;
    endtask

    task automatic test_abandon();
        bit exp_vld[1:6] = '{0, 1, 1, 0, 0, 1};
        int exp_src[1:6] = '{0, 5, 5, 0, 0, 6};
        do_reset();
        req_valid             = 8'b0110_0000;
        req_data[5*DW +: DW]  = 16'h5000;
        req_data[6*DW +: DW]  = 16'h6000;
        for (int e = 1; e <= 6; e++) begin
            if (e == 4) req_valid[5] = 1'b0;
            if (e == 5) begin
                #1;
                n_checks++; if (req_ready !== 8'h00) begin n_fail++; $display("FAIL abandon_idle_ready got=%b exp=00000000", req_ready); end
            end
            tick();
            n_checks++;
            if (dout_valid !== exp_vld[e] || (exp_vld[e] && (dout_src !== 3'(exp_src[e]) || dout !== 16'(16'h1000 * exp_src[e])))) begin
                n_fail++; $display("FAIL abandon edge=%0d got=%b/%0d/%h exp=%b/%0d", e, dout_valid, dout_src, dout, exp_vld[e], exp_src[e]);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        req_valid            = 8'h01;
        req_data[0 +: DW]    = 16'h1234;
        dout_ready           = 1'b0;
        tick();
        #1;
        n_checks++; if (req_ready !== 8'h01) begin n_fail++; $display("FAIL bp_first_ready got=%b exp=00000001", req_ready); end
        tick();
        n_checks++; if (dout_valid !== 1'b1 || dout !== 16'h1234) begin n_fail++; $display("FAIL bp_first_word got=%b/%h exp=1/1234", dout_valid, dout); end
        req_data[0 +: DW] = 16'h5678;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++; if (req_ready !== 8'h00) begin n_fail++; $display("FAIL bp_stall_ready cyc=%0d got=%b exp=00000000", c, req_ready); end
            tick();
            n_checks++; if (dout_valid !== 1'b1 || dout !== 16'h1234) begin n_fail++; $display("FAIL bp_hold cyc=%0d got=%b/%h exp=1/1234", c, dout_valid, dout); end
        end
        dout_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++; if (req_ready !== 8'h01) begin n_fail++; $display("FAIL bp_resume_ready k=%0d got=%b exp=00000001", k, req_ready); end
            tick();
            n_checks++; if (dout_valid !== 1'b1 || dout !== 16'h5678 + 16'(k)) begin n_fail++; $display("FAIL bp_resume_word k=%0d got=%b/%h exp=1/%h", k, dout_valid, dout, 16'h5678 + 16'(k)); end
            req_data[0 +: DW] = 16'h5679 + 16'(k);
        end
        tick();
        n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL bp_burst_end got=%b exp=0", dout_valid); end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        req_valid            = 8'h08;
        req_data[3*DW +: DW] = 16'h3333;
        req_data[7*DW +: DW] = 16'h7777;
        tick();
        tick();
        tick();
        rst       = 1'b1;
        req_valid = 8'h88;
        tick();
        n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_vld got=%b exp=0", dout_valid); end
        rst = 1'b0;
        #1;
        n_checks++; if (req_ready !== 8'h00) begin n_fail++; $display("FAIL midrst_ready got=%b exp=00000000", req_ready); end
        tick();
        #1;
        n_checks++; if (req_ready !== 8'h08) begin n_fail++; $display("FAIL midrst_grant got=%b exp=00001000", req_ready); end
        tick();
        n_checks++; if (dout_valid !== 1'b1 || dout_src !== 3'd3 || dout !== 16'h3333) begin n_fail++; $display("FAIL midrst_word got=%b/%0d/%h exp=1/3/3333", dout_valid, dout_src, dout); end
    endtask

    task automatic test_wrap();
        int srcs[$];
        int exp_s[5] = '{7, 7, 7, 7, 1};
        do_reset();
        req_valid            = 8'h40;
        req_data[1*DW +: DW] = 16'h1111;
        req_data[7*DW +: DW] = 16'h7777;
        tick();
        req_valid = 8'h82;
        tick();
        for (int e = 0; e < 12 && srcs.size() < 5; e++) begin
            tick();
            if (dout_valid) srcs.push_back(int'(dout_src));
        end
        n_checks++;
        if (srcs.size() != 5) begin
            n_fail++; $display("FAIL wrap_timeout got=%0d words exp=5", srcs.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_checks++;
                if (srcs[i] != exp_s[i]) begin n_fail++; $display("FAIL wrap_order idx=%0d got=%0d exp=%0d", i, srcs[i], exp_s[i]); end
            end
        end
    endtask

    task automatic test_random();
        int            owner, words, ptr;
        bit            m_vld;
        logic [DW-1:0] m_dout;
        int            m_src;
        int            seq[NR];
        bit            free, xfer;
        logic [NR-1:0] exp_rdy;
        do_reset();
        owner = -1; words = 0; ptr = 0;
        m_vld = 1'b0; m_dout = '0; m_src = 0;
        for (int i = 0; i < NR; i++) seq[i] = 0;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (req_valid[i]) req_valid[i] = ($urandom_range(0, 7) != 0);
                else              req_valid[i] = ($urandom_range(0, 2) == 0);
                req_data[i*DW +: DW] = 16'((i << 12) | (seq[i] & 12'hFFF));
            end
            dout_ready = ($urandom_range(0, 3) != 0);
            #1;
            free    = !m_vld || dout_ready;
            exp_rdy = (owner >= 0 && free) ? (8'b1 << owner) : 8'h00;
            n_checks++;
            if (req_ready !== exp_rdy) begin n_fail++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", c, req_ready, exp_rdy); end
            xfer = (owner >= 0) && req_valid[owner] && free;
            if (!xfer && dout_ready) m_vld = 1'b0;
            if (owner < 0) begin
                if (|req_valid) begin owner = first_from(ptr, req_valid); words = 0; end
            end else if (!req_valid[owner]) begin
                ptr = (owner + 1) % NR; owner = -1;
            end else if (xfer) begin
                m_vld  = 1'b1;
                m_dout = req_data[owner*DW +: DW];
                m_src  = owner;
                seq[owner]++;
                words++;
                if (words == MB) begin ptr = (owner + 1) % NR; owner = -1; end
            end
            tick();
            n_checks++;
            if (dout_valid !== m_vld || (m_vld && (dout !== m_dout || dout_src !== 3'(m_src)))) begin
                n_fail++; $display("FAIL rand_out cyc=%0d got=%b/%h/%0d exp=%b/%h/%0d", c, dout_valid, dout, dout_src, m_vld, m_dout, m_src);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_burst();
        test_round_robin_burst1();
        test_abandon();
        test_backpressure();
        test_reset_mid_burst();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
